// File: rtl/udp_writer.sv
// udp_writer: captures a CAPACITY-byte word on a send strike, requests the UDP
// TX path, then streams the bytes MSB-first with a last marker, followed by a
// minimum idle gap before the next frame may be requested.
module udp_writer #(
  parameter int CAPACITY   = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  send,
  input  logic [CAPACITY*8-1:0] i_data,
  output logic                  tx_req,
  input  logic                  tx_ack,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_last,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int IW = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(CAPACITY - 1);
  localparam logic [GW-1:0] GAP_INIT = GW'(GAP_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SEND, S_GAP} state_t;

  state_t                state, state_nx;
  logic [CAPACITY*8-1:0] shadow, shadow_nx;
  logic [IW-1:0]         idx, idx_nx;
  logic [GW-1:0]         gcnt, gcnt_nx;
  logic                  done_q, done_nx;
  logic                  err_q, err_nx;
  logic                  hs;
  logic [7:0]            cur_byte;

  // Outputs decode straight from state so reset clears them asynchronously.
  assign busy     = (state != S_IDLE);
  assign tx_req   = (state == S_REQ) || (state == S_SEND);
  assign tx_valid = (state == S_SEND);
  assign tx_last  = (state == S_SEND) && (idx == LAST_IDX);
  assign tx_data  = (state == S_SEND) ? cur_byte : 8'h00;
  assign done     = done_q;
  assign error    = err_q;
  assign hs       = tx_valid & tx_ready;

  // Byte select: idx 0 maps to the top byte of the shadow word.
  always_comb begin
    cur_byte = 8'h00;
    for (int i = 0; i < CAPACITY; i++)
      if (idx == IW'(CAPACITY - 1 - i)) cur_byte = shadow[i*8 +: 8];
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      shadow <= '0;
      idx    <= '0;
      gcnt   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      shadow <= shadow_nx;
      idx    <= idx_nx;
      gcnt   <= gcnt_nx;
      done_q <= done_nx;
      err_q  <= err_nx;
    end
  end

  // Next-state logic; a send outside IDLE is dropped and flagged.
  always_comb begin
    state_nx  = state;
    shadow_nx = shadow;
    idx_nx    = idx;
    gcnt_nx   = gcnt;
    done_nx   = 1'b0;
    err_nx    = send && (state != S_IDLE);
    case (state)
      S_IDLE: if (send) begin
        state_nx  = S_REQ;
        shadow_nx = i_data;
        idx_nx    = '0;
      end
      S_REQ: if (tx_ack) state_nx = S_SEND;
      S_SEND: if (hs) begin
        if (idx == LAST_IDX) begin
          state_nx = S_GAP;
          gcnt_nx  = GAP_INIT;
          done_nx  = 1'b1;
        end else begin
          idx_nx = idx + IW'(1);
        end
      end
      S_GAP: begin
        if (gcnt == '0) state_nx = S_IDLE;
        else            gcnt_nx  = gcnt - GW'(1);
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_udp_writer.sv
// Directed bench for udp_writer: a 4-byte/gap-2 instance and a 1-byte/gap-0
// instance share the clock and reset. Inputs change and outputs are checked
// on the falling edge.
module tb_udp_writer;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // CAPACITY=4, GAP_CYCLES=2 instance
  logic        a_send = 0, a_ack = 0, a_ready = 1;
  logic [31:0] a_idata = '0;
  logic        a_req, a_valid, a_last, a_busy, a_done, a_err;
  logic [7:0]  a_data;

  // CAPACITY=1, GAP_CYCLES=0 instance
  logic        b_send = 0, b_ack = 0, b_ready = 1;
  logic [7:0]  b_idata = '0;
  logic        b_req, b_valid, b_last, b_busy, b_done, b_err;
  logic [7:0]  b_data;

  int checks = 0;
  int errors = 0;

  udp_writer #(.CAPACITY(4), .GAP_CYCLES(2)) dut_a (
    .clk(clk), .rstn(rstn), .send(a_send), .i_data(a_idata),
    .tx_req(a_req), .tx_ack(a_ack), .tx_valid(a_valid), .tx_ready(a_ready),
    .tx_data(a_data), .tx_last(a_last), .busy(a_busy), .done(a_done), .error(a_err));

  udp_writer #(.CAPACITY(1), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rstn(rstn), .send(b_send), .i_data(b_idata),
    .tx_req(b_req), .tx_ack(b_ack), .tx_valid(b_valid), .tx_ready(b_ready),
    .tx_data(b_data), .tx_last(b_last), .busy(b_busy), .done(b_done), .error(b_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full 4-byte frame on instance A. Entered and left on a falling edge with
  // the FSM expected in IDLE. pat gives tx_ready per SEND cycle (bit k).
  // stale zeroes i_data after the strike; coll strikes send during SEND,
  // during the first GAP cycle and during the GAP->IDLE cycle.
  task automatic frame4(input logic [31:0] d, input logic [15:0] pat,
                        input bit stale, input bit coll);
    int idx = 0;
    int k = 0;
    chk("a idle before send", a_busy, 0);
    a_send = 1; a_idata = d;
    @(negedge clk);
    a_send = 0;
    if (stale) a_idata = '0;
    chk("a req rises", a_req, 1);
    chk("a no valid in req", a_valid, 0);
    chk("a busy in req", a_busy, 1);
    @(negedge clk);
    chk("a req held", a_req, 1);
    @(negedge clk);
    chk("a req held 2", a_req, 1);
    a_ack = 1;
    @(negedge clk);
    a_ack = 0;
    while (idx < 4 && k < 32) begin
      a_ready = (k < 16) ? pat[k] : 1'b1;
      a_send  = coll && (k == 1);
      chk("a valid", a_valid, 1);
      chk("a data", a_data, d[31 - 8*idx -: 8]);
      chk("a last", a_last, (idx == 3));
      chk("a req in send", a_req, 1);
      chk("a err in send", a_err, coll && (k == 2));
      if (a_ready) idx++;
      k++;
      @(negedge clk);
    end
    if (idx < 4) chk("a frame timeout", idx, 4);
    a_send  = coll;
    a_ready = 1;
    chk("a done pulse", a_done, 1);
    chk("a valid off in gap", a_valid, 0);
    chk("a req off in gap", a_req, 0);
    chk("a busy in gap", a_busy, 1);
    @(negedge clk);
    a_send = 0;
    chk("a err gap", a_err, coll);
    chk("a done single", a_done, 0);
    chk("a busy gap 2", a_busy, 1);
    @(negedge clk);
    chk("a busy gap 3", a_busy, 1);
    a_send = coll;
    @(negedge clk);
    a_send = 0;
    chk("a idle after gap", a_busy, 0);
    chk("a err at gap end", a_err, coll);
    chk("a no req after frame", a_req, 0);
  endtask

  // One-byte frame on instance B, entered and left on a falling edge in IDLE.
  task automatic frame1(input logic [7:0] d);
    chk("b idle before send", b_busy, 0);
    b_send = 1; b_idata = d;
    @(negedge clk);
    b_send = 0;
    chk("b req", b_req, 1);
    chk("b no valid in req", b_valid, 0);
    b_ack = 1;
    @(negedge clk);
    b_ack = 0;
    chk("b valid", b_valid, 1);
    chk("b data", b_data, d);
    chk("b last", b_last, 1);
    @(negedge clk);
    chk("b done", b_done, 1);
    chk("b busy in gap", b_busy, 1);
    chk("b valid off", b_valid, 0);
    @(negedge clk);
    chk("b idle after gap", b_busy, 0);
    chk("b done single", b_done, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst a busy", a_busy, 0);
    chk("rst a req", a_req, 0);
    chk("rst a valid", a_valid, 0);
    chk("rst a data", a_data, 0);
    chk("rst a done", a_done, 0);
    chk("rst a err", a_err, 0);
    rstn = 1;
    @(negedge clk);

    // Basic frame with i_data cleared right after the strike.
    frame4(32'hDEADBEEF, 16'hFFFF, 1'b1, 1'b0);
    // Backpressure: ready 1,0,0,1,0,1,1.
    frame4(32'hDEADBEEF, 16'b0000_0000_0110_1001, 1'b0, 1'b0);
    // Collisions, then a send on the first IDLE cycle.
    frame4(32'h01234567, 16'hFFFF, 1'b0, 1'b1);
    frame4(32'h89ABCDEF, 16'hFFFF, 1'b0, 1'b0);

    // Reset after two of four bytes have been accepted.
    a_send = 1; a_idata = 32'hCAFEF00D;
    @(negedge clk);
    a_send = 0;
    a_ack = 1;
    @(negedge clk);
    a_ack = 0;
    chk("pre-rst byte0", a_data, 8'hCA);
    @(negedge clk);
    chk("pre-rst byte1", a_data, 8'hFE);
    @(negedge clk);
    chk("pre-rst byte2", a_data, 8'hF0);
    rstn = 0;
    #1;
    chk("mid rst valid", a_valid, 0);
    chk("mid rst req", a_req, 0);
    chk("mid rst busy", a_busy, 0);
    chk("mid rst data", a_data, 0);
    chk("mid rst last", a_last, 0);
    @(negedge clk);
    rstn = 1;
    chk("no done after rst", a_done, 0);
    @(negedge clk);
    chk("no done after rst 2", a_done, 0);
    frame4(32'hDEADBEEF, 16'hFFFF, 1'b0, 1'b0);

    // Single-byte instance, back-to-back frames.
    frame1(8'h5A);
    frame1(8'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
